pulse_train_gen: RTL

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/phase_down_counter.sv | 27 ++
 rtl/pulse_train_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared state encoding and default widths for the pulse train generator.
package pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int WID_W_DEF = 8;

endpackage

// File: rtl/phase_down_counter.sv
// Phase-length down counter: counts from the loaded value to 1 and holds.
module phase_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   output logic         last
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && count > W'(1)) begin
         count <= count - W'(1);
      end
   end

   assign last = (count == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: N pulses, H cycles high, max(L,1) cycles low.
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WID_W = WID_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] pulse_count,
   input  logic [WID_W-1:0] high_cycles,
   input  logic [WID_W-1:0] low_cycles,
   output logic             out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [CNT_W-1:0] rem;
   logic [WID_W-1:0] h_lat;
   logic [WID_W-1:0] l_lat;
   logic [WID_W-1:0] l_len;
   logic [WID_W-1:0] ld_val;
   logic             ld;
   logic             en;
   logic             last;
   logic             go_ok;
   logic             more;

   assign go_ok = start && (pulse_count != '0) && (high_cycles != '0);
   assign l_len = (l_lat == '0) ? WID_W'(1) : l_lat;
   assign more  = (rem > CNT_W'(1));

   // Reload H on every entry to HIGH, max(L,1) on entry to LOW.
   always_comb begin
      ld     = 1'b0;
      en     = 1'b0;
      ld_val = h_lat;
      unique case (state)
         IDLE: begin
            ld     = go_ok;
            ld_val = high_cycles;
         end
         HIGH: begin
            if (!abort) begin
               if (last && more) begin
                  ld     = 1'b1;
                  ld_val = l_len;
               end else begin
                  en = 1'b1;
               end
            end
         end
         LOW: begin
            if (!abort) begin
               ld = last;
               en = !last;
            end
         end
         default: ;
      endcase
   end

   phase_down_counter #(
      .W(WID_W)
   ) u_phase (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (ld_val),
      .enable   (en),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         out   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         rem   <= '0;
         h_lat <= '0;
         l_lat <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (go_ok) begin
                     state <= HIGH;
                     out   <= 1'b1;
                     rem   <= pulse_count;
                     h_lat <= high_cycles;
                     l_lat <= low_cycles;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            HIGH: begin
               if (last && !abort) begin
                  rem <= rem - CNT_W'(1);
               end
               if (abort || (last && !more)) begin
                  state <= DONE;
                  out   <= 1'b0;
                  done  <= 1'b1;
               end else if (last) begin
                  state <= LOW;
                  out   <= 1'b0;
               end
            end
            LOW: begin
               if (abort) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (last) begin
                  state <= HIGH;
                  out   <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
